unpacker_stream: RTL

//  Parametrised successor of the fixed 160B->32B unpacker FSM. Splits one wide input beat
//  (up to IN_BYTES valid bytes) into ceil(vbc/OUT_BYTES) narrow output beats.

---
 rtl/unpacker_pkg.sv | 22 ++
 rtl/unpacker_chunk_sel.sv | 33 +++
 rtl/unpacker_stream.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/unpacker_pkg.sv
// unpacker_pkg: shared types and helpers for the wide-to-narrow beat unpacker.
// Default geometry matches the original 160B -> 32B fabric adapter.
package unpacker_pkg;

  typedef enum logic [0:0] {
    UNP_IDLE,
    UNP_BUSY
  } unp_state_t;

  localparam int DEF_IN_BYTES  = 160;
  localparam int DEF_OUT_BYTES = 32;
  localparam int DEF_VBC_W     = 8;
  localparam int N_CHUNK       = DEF_IN_BYTES / DEF_OUT_BYTES;

  function automatic int unsigned ceil_div(
    input int unsigned vbc,
    input int unsigned out_bytes
  );
    return (vbc + out_bytes - 1) / out_bytes;
  endfunction

endpackage

// File: rtl/unpacker_chunk_sel.sv
// unpacker_chunk_sel: picks narrow chunk k out of a wide beat.
// Bytes past the chunk's valid count are forced to zero.
module unpacker_chunk_sel #(
  parameter int IN_BYTES  = 160,
  parameter int OUT_BYTES = 32,
  parameter int VBC_W     = 8,
  parameter int CW        = 3
) (
  input  logic [IN_BYTES*8-1:0]  src,
  input  logic [VBC_W-1:0]       vbc,
  input  logic [CW-1:0]          k,
  output logic [OUT_BYTES*8-1:0] data,
  output logic [VBC_W-1:0]       cnt
);

  logic [VBC_W:0]         base;
  logic [VBC_W:0]         rem;
  logic [OUT_BYTES*8-1:0] raw;

  // Byte count of chunk k (one bit wider so it cannot wrap), then masked slice.
  always_comb begin
    base = (VBC_W+1)'(int'(k) * OUT_BYTES);
    rem  = {1'b0, vbc} - base;
    cnt  = (rem > (VBC_W+1)'(OUT_BYTES))
         ? VBC_W'(OUT_BYTES) : rem[VBC_W-1:0];
    raw  = src[int'(k)*OUT_BYTES*8 +: OUT_BYTES*8];
    data = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (VBC_W'(i) < cnt) data[i*8 +: 8] = raw[i*8 +: 8];
    end
  end

endmodule

// File: rtl/unpacker_stream.sv
// unpacker_stream: splits one wide beat into ceil(vbc/OUT_BYTES) narrow beats.
// Valid/ready on both sides; framing and length errors pulse err.
module unpacker_stream
  import unpacker_pkg::*;
#(
  parameter int IN_BYTES  = DEF_IN_BYTES,
  parameter int OUT_BYTES = DEF_OUT_BYTES,
  parameter int VBC_W     = DEF_VBC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   val,
  input  logic                   sop,
  input  logic                   eop,
  input  logic [VBC_W-1:0]       vbc,
  input  logic [IN_BYTES*8-1:0]  data,
  output logic                   ready,
  output logic                   o_val,
  input  logic                   o_rdy,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic [VBC_W-1:0]       o_vbc,
  output logic [OUT_BYTES*8-1:0] o_data,
  output logic                   idle,
  output logic                   err
);

  localparam int NC = IN_BYTES / OUT_BYTES;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int IW = IN_BYTES * 8;
  localparam int OW = OUT_BYTES * 8;

  if (IN_BYTES % OUT_BYTES != 0) begin : g_bad_ratio
    $error("IN_BYTES must be a multiple of OUT_BYTES");
  end
  if ((1 << VBC_W) <= IN_BYTES) begin : g_bad_vbc_w
    $error("VBC_W too narrow to hold IN_BYTES");
  end

  unp_state_t state;
  unp_state_t state_nx;

  logic [IW-1:0]    buf_data;
  logic [VBC_W-1:0] buf_vbc;
  logic             buf_eop;
  logic [CW-1:0]    chunk;
  logic [CW-1:0]    nxt_chunk;
  logic [CW-1:0]    last_idx;
  logic [CW-1:0]    new_last;
  logic             in_pkt;

  logic take;
  logic last_chunk;
  logic acc;
  logic bad_len;
  logic load;
  logic frame_err;

  logic [IW-1:0]    sel_src;
  logic [VBC_W-1:0] sel_vbc;
  logic [CW-1:0]    sel_k;
  logic [OW-1:0]    sel_data;
  logic [VBC_W-1:0] sel_cnt;

  assign take       = o_val & o_rdy;
  assign last_chunk = (chunk == last_idx);
  assign idle       = (state == UNP_IDLE);
  assign ready      = idle | (take & last_chunk);
  assign acc        = val & ready;
  assign bad_len    = {1'b0, vbc} > (VBC_W+1)'(IN_BYTES);
  assign load       = acc & (vbc != '0) & ~bad_len;
  assign frame_err  = sop ? in_pkt : ~in_pkt;
  assign nxt_chunk  = chunk + CW'(1);
  assign new_last   = CW'(ceil_div(32'(vbc), 32'(OUT_BYTES)) - 1);

  // A fresh beat feeds chunk 0 straight from the input for one-cycle latency.
  assign sel_src = load ? data : buf_data;
  assign sel_vbc = load ? vbc : buf_vbc;
  assign sel_k   = load ? '0 : nxt_chunk;

  unpacker_chunk_sel #(
    .IN_BYTES  (IN_BYTES),
    .OUT_BYTES (OUT_BYTES),
    .VBC_W     (VBC_W),
    .CW        (CW)
  ) u_sel (
    .src  (sel_src),
    .vbc  (sel_vbc),
    .k    (sel_k),
    .data (sel_data),
    .cnt  (sel_cnt)
  );

  // Next state: a loaded beat always wins over draining the last chunk.
  always_comb begin
    state_nx = state;
    if (load) begin
      state_nx = UNP_BUSY;
    end else if (take & last_chunk) begin
      state_nx = UNP_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= UNP_IDLE;
    else       state <= state_nx;
  end

  // Beat buffer, chunk counter, packet tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_data <= '0;
      buf_vbc  <= '0;
      buf_eop  <= 1'b0;
      chunk    <= '0;
      last_idx <= '0;
      in_pkt   <= 1'b0;
      err      <= 1'b0;
      o_val    <= 1'b0;
      o_sop    <= 1'b0;
      o_eop    <= 1'b0;
      o_vbc    <= '0;
      o_data   <= '0;
    end else begin
      err <= (acc & bad_len) | (load & frame_err);
      if (load) begin
        buf_data <= data;
        buf_vbc  <= vbc;
        buf_eop  <= eop;
        chunk    <= '0;
        last_idx <= new_last;
        in_pkt   <= ~eop;
        o_val    <= 1'b1;
        o_sop    <= sop;
        o_eop    <= eop & (new_last == '0);
        o_vbc    <= sel_cnt;
        o_data   <= sel_data;
      end else if (take) begin
        if (last_chunk) begin
          o_val  <= 1'b0;
          o_sop  <= 1'b0;
          o_eop  <= 1'b0;
          o_vbc  <= '0;
          o_data <= '0;
        end else begin
          chunk  <= nxt_chunk;
          o_sop  <= 1'b0;
          o_eop  <= buf_eop & (nxt_chunk == last_idx);
          o_vbc  <= sel_cnt;
          o_data <= sel_data;
        end
      end
    end
  end

endmodule
